bist_scan_controller: RTL and testbench
=======================================

Name: bist_scan_controller

Overview:
- BIST sequencer that drives the far end of a single scan chain.
- Generates pseudo-random scan-in data with an LFSR and drives the shift/capture control.
- Compacts the chain's serial output into a MISR and compares the final signature against a golden value.
- Sits beside each scan chain instance, one controller per chain, and is triggered from the top-level test logic.

Parameters:
- CHAIN_LEN, 7, number of flops in the attached scan chain.
- NUM_PATTERNS, 16, number of LFSR patterns shifted in and captured.
- LFSR_SEED, 16'hACE1, LFSR value loaded at start; must be non-zero.
- LFSR_TAPS, 16'hB400, Galois feedback mask for the pattern generator.
- MISR_TAPS, 16'hB400, Galois feedback mask for the response compactor.
- GOLDEN_SIG, 16'h0000, expected MISR value at the end of the run.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle or done.
- chain_out  in  1  serial response from the chain (the chain's registered scan_out).
- chain_in  out  1  serial stimulus to the chain's scan_in.
- test_control  out  1  1 = shift, 0 = capture/functional.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run end until the next start or reset.
- pass  out  1  valid while done; 1 when signature equals GOLDEN_SIG.
- signature  out  16  current MISR contents.

Behaviour:
- Reset (synchronous) values: state IDLE, chain_in=0, test_control=0, busy=0, done=0, pass=0, LFSR=LFSR_SEED, MISR=0, all counters 0, compact_en=0, shift_q=0.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DRAIN, DONE.
- IDLE or DONE with start=1:
  - load LFSR_SEED, clear MISR and counters, clear done, pass and compact_en;
  - go to SHIFT.
- start is ignored in any other state.
- SHIFT:
  - test_control=1 and chain_in=lfsr[0].
  - Each cycle, lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - After CHAIN_LEN cycles, go to CAPTURE.
- CAPTURE:
  - test_control=0 for exactly one cycle; chain_in=0; compact_en <= 1.
  - If this was pattern NUM_PATTERNS-1, go to UNLOAD; otherwise increment the pattern count and go to SHIFT.
- UNLOAD: test_control=1, chain_in=0 for CHAIN_LEN cycles, then go to DRAIN.
- DRAIN: test_control=0 for one cycle so the last registered chain bit is compacted; then go to DONE.
- DONE: done=1, pass=(MISR==GOLDEN_SIG), busy=0; hold until start or reset.
- busy=1 in SHIFT, CAPTURE, UNLOAD and DRAIN.
- Outputs test_control, chain_in, busy and done are registered from state, so they change on the clock edge that enters the state.
- Compaction:
  - shift_q is test_control delayed by one cycle.
  - When shift_q & compact_en: misr <= {misr[14:0],1'b0} ^ (misr[15] ? MISR_TAPS : 0) ^ {15'b0, chain_out}.
  - Pattern 0's shift-out is never compacted, because uninitialised chain contents are masked.
  - Total compacted bits = NUM_PATTERNS*CHAIN_LEN.
- Latency: done rises NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles after the cycle start is sampled. With the defaults this is 136.
- Reset mid-run: the next edge forces all outputs and state to their reset values, and no partial signature survives.
- start and reset in the same cycle: reset wins.
- start in DONE restarts immediately; done drops on the same edge busy rises.

Decomposition:
- Package bist_pkg holds:
  - the state enum;
  - LFSR/MISR width constant 16;
  - default seed and tap constants.
- One sub-module, bist_misr:
  - 16-bit Galois MISR with inputs clear, enable and serial data, and parameter TAPS;
  - instantiated once for compaction.
- The LFSR stays inline.

Test Plan:
1. Assert reset for 2 cycles -> all outputs 0, signature=0; start held low keeps test_control=0 indefinitely.
2. Pulse start -> test_control=1 for 7 cycles with chain_in = 1,0,0,0,0,1,1; then test_control=0 for one cycle; then shifting resumes.
3. Attach a behavioural 7-bit chain model (holds in capture) and pulse start -> exactly 16 capture pulses, then a 7-cycle zero unload; done=1 and busy=0 exactly 136 cycles after start; signature matches the bench's reference MISR model.
4. Tie chain_out=0 with GOLDEN_SIG=0 -> signature=16'h0000, pass=1. Then flip chain_out to 1 for one compacted cycle -> pass=0.
5. Set GOLDEN_SIG to the value from scenario 3 and inject a stuck-at-1 on chain flop 3 in the model -> pass=0; remove the fault and rerun via start from DONE -> pass=1.
6. Assert reset during the 4th SHIFT cycle of pattern 5 -> next edge gives test_control=0, busy=0, signature=0. Pulse start while busy in a separate run -> ignored, and the cycle count to done is unchanged.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the scan-chain BIST controller and its MISR.
package bist_pkg;

   localparam int SIG_W = 16;

   localparam logic [SIG_W-1:0] DEF_LFSR_SEED  = 16'hACE1;
   localparam logic [SIG_W-1:0] DEF_LFSR_TAPS  = 16'hB400;
   localparam logic [SIG_W-1:0] DEF_MISR_TAPS  = 16'hB400;
   localparam logic [SIG_W-1:0] DEF_GOLDEN_SIG = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_DRAIN,
      ST_DONE
   } bist_state_e;

   // Right-shifting Galois step used by the pattern generator.
   function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] v,
                                                  input logic [SIG_W-1:0] taps);
      return (v >> 1) ^ (v[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit left-shifting Galois MISR compacting one serial response bit per enabled cycle.
module bist_misr
   import bist_pkg::*;
#(
   parameter logic [SIG_W-1:0] TAPS = DEF_MISR_TAPS
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic             i_din,
   output logic [SIG_W-1:0] o_sig
);

   logic [SIG_W-1:0] r_sig;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         r_sig <= '0;
      end else if (i_enable) begin
         r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? TAPS : '0)
                  ^ {{(SIG_W-1){1'b0}}, i_din};
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/bist_scan_controller.sv
// Scan BIST sequencer: LFSR stimulus into one chain, MISR compaction of its response,
// final signature compared against a golden value.
module bist_scan_controller
   import bist_pkg::*;
#(
   parameter int               CHAIN_LEN    = 7,
   parameter int               NUM_PATTERNS = 16,
   parameter logic [SIG_W-1:0] LFSR_SEED    = DEF_LFSR_SEED,
   parameter logic [SIG_W-1:0] LFSR_TAPS    = DEF_LFSR_TAPS,
   parameter logic [SIG_W-1:0] MISR_TAPS    = DEF_MISR_TAPS,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = DEF_GOLDEN_SIG
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             chain_out,
   output logic             chain_in,
   output logic             test_control,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int PAT_W = $clog2(NUM_PATTERNS + 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

   bist_state_e      r_state, w_state_nxt;
   logic [SIG_W-1:0] r_lfsr, w_lfsr_nxt;
   logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [PAT_W-1:0] r_pat_cnt, w_pat_cnt_nxt;
   logic             r_compact_en, w_compact_en_nxt;
   logic             r_shift_q;
   logic             r_chain_in, r_test_control, r_busy, r_done;
   logic             w_misr_clear;
   logic             w_misr_en;

   always_comb begin
      w_state_nxt      = r_state;
      w_lfsr_nxt       = r_lfsr;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_pat_cnt_nxt    = r_pat_cnt;
      w_compact_en_nxt = r_compact_en;
      w_misr_clear     = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt      = ST_SHIFT;
               w_lfsr_nxt       = LFSR_SEED;
               w_bit_cnt_nxt    = '0;
               w_pat_cnt_nxt    = '0;
               w_compact_en_nxt = 1'b0;
               w_misr_clear     = 1'b1;
            end
         end
         ST_SHIFT: begin
            w_lfsr_nxt = lfsr_step(r_lfsr, LFSR_TAPS);
            if (r_bit_cnt == BIT_LAST) begin
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_CAPTURE;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         ST_CAPTURE: begin
            // From here on every shift-out holds captured data, not the chain's power-up junk.
            w_compact_en_nxt = 1'b1;
            if (r_pat_cnt == PAT_LAST) begin
               w_state_nxt = ST_UNLOAD;
            end else begin
               w_pat_cnt_nxt = r_pat_cnt + 1'b1;
               w_state_nxt   = ST_SHIFT;
            end
         end
         ST_UNLOAD: begin
            if (r_bit_cnt == BIT_LAST) begin
               w_bit_cnt_nxt = '0;
               w_state_nxt   = ST_DRAIN;
            end else begin
               w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
         end
         ST_DRAIN: w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they switch on the edge entering a state.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_lfsr         <= LFSR_SEED;
         r_bit_cnt      <= '0;
         r_pat_cnt      <= '0;
         r_compact_en   <= 1'b0;
         r_shift_q      <= 1'b0;
         r_chain_in     <= 1'b0;
         r_test_control <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_lfsr         <= w_lfsr_nxt;
         r_bit_cnt      <= w_bit_cnt_nxt;
         r_pat_cnt      <= w_pat_cnt_nxt;
         r_compact_en   <= w_compact_en_nxt;
         r_shift_q      <= r_test_control;
         r_chain_in     <= (w_state_nxt == ST_SHIFT) & w_lfsr_nxt[0];
         r_test_control <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_UNLOAD);
         r_busy         <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_CAPTURE) ||
                           (w_state_nxt == ST_UNLOAD) || (w_state_nxt == ST_DRAIN);
         r_done         <= (w_state_nxt == ST_DONE);
      end
   end

   // chain_out is a registered scan_out, so it trails test_control by one cycle.
   assign w_misr_en = r_shift_q & r_compact_en;

   bist_misr #(
      .TAPS(MISR_TAPS)
   ) u_misr (
      .i_clock (clock),
      .i_reset (reset),
      .i_clear (w_misr_clear),
      .i_enable(w_misr_en),
      .i_din   (chain_out),
      .o_sig   (signature)
   );

   assign chain_in     = r_chain_in;
   assign test_control = r_test_control;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pass         = r_done && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_bist_scan_controller.sv
// Bench for bist_scan_controller: behavioural 7-flop chain with registered scan_out,
// reference signature computed from the LFSR bit stream and the MISR rule.
`timescale 1ns/1ps
module tb_bist_scan_controller;

   localparam int CL      = 7;
   localparam int NP      = 16;
   localparam int NBITS   = CL * NP;
   localparam int RUN_CYC = NP * (CL + 1) + CL + 1;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam logic [15:0] LTAPS = 16'hB400;
   localparam logic [15:0] MTAPS = 16'hB400;

   // mode 0: the LFSR stream as seen through a fault-free holding chain; mode 1: a lone 1 at idx.
   function automatic logic [15:0] ref_sig(input int mode, input int idx);
      logic [15:0] l;
      logic [15:0] m;
      logic        b;
      l = SEED;
      m = 16'h0000;
      for (int n = 0; n < NBITS; n++) begin
         if (mode == 0) b = l[0];
         else           b = (n == idx);
         l = (l >> 1) ^ (l[0] ? LTAPS : 16'h0000);
         m = {m[14:0], 1'b0} ^ (m[15] ? MTAPS : 16'h0000) ^ {15'h0000, b};
      end
      return m;
   endfunction

   localparam logic [15:0] REF_SIG = ref_sig(0, 0);

   logic        clock = 1'b0;
   logic        reset, start;
   logic        chain_out;
   logic        ci_a, tc_a, busy_a, done_a, pass_a;
   logic        ci_b, tc_b, busy_b, done_b, pass_b;
   logic [15:0] sig_a, sig_b;

   logic [CL-1:0] chain_q;
   logic          so_q;
   logic          chain_load, stuck3, tie_en, tie_val;
   logic [CL-1:0] chain_seed;
   logic          stream [NBITS];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   bist_scan_controller u_dut_a (
      .clock(clock), .reset(reset), .start(start), .chain_out(chain_out),
      .chain_in(ci_a), .test_control(tc_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .signature(sig_a)
   );

   bist_scan_controller #(.GOLDEN_SIG(REF_SIG)) u_dut_b (
      .clock(clock), .reset(reset), .start(start), .chain_out(chain_out),
      .chain_in(ci_b), .test_control(tc_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .signature(sig_b)
   );

   // Scan chain: shifts when test_control=1, holds in capture, scan_out registered every cycle.
   always @(posedge clock) begin
      so_q <= chain_q[CL-1];
      if (chain_load)  chain_q <= chain_seed;
      else if (tc_a)   chain_q <= {chain_q[CL-2:0], ci_a} | (stuck3 ? 7'b0001000 : 7'b0000000);
      else             chain_q <= chain_q | (stuck3 ? 7'b0001000 : 7'b0000000);
   end

   assign chain_out = tie_en ? tie_val : so_q;

   function automatic logic exp_tc(input int k);
      if (k < NP * (CL + 1)) return (k % (CL + 1)) != CL;
      return k < NP * (CL + 1) + CL;
   endfunction

   function automatic logic exp_ci(input int k);
      if (k < NP * (CL + 1) && (k % (CL + 1)) != CL)
         return stream[(k / (CL + 1)) * CL + (k % (CL + 1))];
      return 1'b0;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic load_chain();
      chain_seed = CL'($urandom);
      chain_load = 1'b1;
      @(negedge clock);
      chain_load = 1'b0;
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (done_a !== 1'b1 && k < RUN_CYC + 40) begin
         @(negedge clock);
         k++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if ({tc_a, ci_a, busy_a, done_a, pass_a} !== 5'b0 || sig_a !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: got tc=%b ci=%b busy=%b done=%b pass=%b sig=%h required all 0",
                  tc_a, ci_a, busy_a, done_a, pass_a, sig_a);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checks++;
         if (tc_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold cycle %0d: got tc=%b busy=%b required 0/0", i, tc_a, busy_a);
         end
      end
   endtask

   task automatic test_shift_pattern();
      logic [6:0] first7;
      logic       want_tc, want_ci;
      first7 = 7'b1100001;
      pulse_start();
      for (int k = 0; k <= CL + 1; k++) begin
         want_tc = (k != CL);
         want_ci = (k < CL) ? first7[k] : ((k == CL) ? 1'b0 : stream[CL]);
         checks++;
         if (tc_a !== want_tc || ci_a !== want_ci) begin
            errors++;
            $display("FAIL shift_seq k=%0d: got tc=%b ci=%b required tc=%b ci=%b",
                     k, tc_a, ci_a, want_tc, want_ci);
         end
         @(negedge clock);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_full_run();
      int caps;
      caps = 0;
      load_chain();
      pulse_start();
      for (int k = 0; k < RUN_CYC; k++) begin
         checks++;
         if (tc_a !== exp_tc(k) || tc_b !== exp_tc(k) || ci_a !== exp_ci(k) || ci_b !== exp_ci(k)) begin
            errors++;
            $display("FAIL run_ctrl k=%0d: got tc=%b/%b ci=%b/%b required tc=%b ci=%b",
                     k, tc_a, tc_b, ci_a, ci_b, exp_tc(k), exp_ci(k));
         end
         checks++;
         if (busy_a !== 1'b1 || done_a !== 1'b0 || busy_b !== 1'b1 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL run_busy k=%0d: got busy=%b done=%b required 1/0", k, busy_a, done_a);
         end
         if (k < NP * (CL + 1) && tc_a === 1'b0) caps++;
         @(negedge clock);
      end
      checks++;
      if (caps != NP) begin
         errors++;
         $display("FAIL capture_count: got %0d required %0d", caps, NP);
      end
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || done_b !== 1'b1) begin
         errors++;
         $display("FAIL done_latency: got done=%b busy=%b at %0d required 1/0", done_a, busy_a, RUN_CYC);
      end
      checks++;
      if (sig_a !== REF_SIG || sig_b !== REF_SIG) begin
         errors++;
         $display("FAIL run_signature: got %h/%h required %h", sig_a, sig_b, REF_SIG);
      end
      checks++;
      if (pass_a !== (REF_SIG == 16'h0000) || pass_b !== 1'b1) begin
         errors++;
         $display("FAIL run_pass: got %b/%b required %b/1", pass_a, pass_b, REF_SIG == 16'h0000);
      end
   endtask

   task automatic test_tied_signature();
      int          k, idx, hit;
      logic [15:0] want;
      tie_en  = 1'b1;
      tie_val = 1'b0;
      pulse_start();
      wait_done(k);
      checks++;
      if (sig_a !== 16'h0000 || pass_a !== 1'b1 || k != RUN_CYC) begin
         errors++;
         $display("FAIL tied_zero: got sig=%h pass=%b cycles=%0d required 0000/1/%0d", sig_a, pass_a, k, RUN_CYC);
      end
      idx  = $urandom_range(0, NBITS - 1);
      hit  = (CL + 1) * (idx / CL) + CL + 2 + (idx % CL);
      want = ref_sig(1, idx);
      pulse_start();
      k = 0;
      while (done_a !== 1'b1 && k < RUN_CYC + 40) begin
         tie_val = (k == hit);
         @(negedge clock);
         k++;
      end
      tie_val = 1'b0;
      checks++;
      if (sig_a !== want || k != RUN_CYC) begin
         errors++;
         $display("FAIL single_one bit %0d: got sig=%h cycles=%0d required %h/%0d", idx, sig_a, k, want, RUN_CYC);
      end
      checks++;
      if (pass_a !== (want == 16'h0000)) begin
         errors++;
         $display("FAIL single_one_pass: got %b required %b", pass_a, want == 16'h0000);
      end
      tie_en = 1'b0;
   endtask

   task automatic test_stuck_fault();
      int k;
      stuck3 = 1'b1;
      load_chain();
      pulse_start();
      wait_done(k);
      checks++;
      if (done_b !== 1'b1 || pass_b !== 1'b0 || sig_b === REF_SIG) begin
         errors++;
         $display("FAIL stuck_fault: got done=%b pass=%b sig=%h required 1/0/not %h", done_b, pass_b, sig_b, REF_SIG);
      end
      stuck3 = 1'b0;
      pulse_start();
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b1 || pass_b !== 1'b0) begin
         errors++;
         $display("FAIL restart_edge: got done=%b busy=%b pass=%b required 0/1/0", done_a, busy_a, pass_b);
      end
      wait_done(k);
      checks++;
      if (pass_b !== 1'b1 || sig_b !== REF_SIG || k != RUN_CYC) begin
         errors++;
         $display("FAIL fault_removed: got pass=%b sig=%h cycles=%0d required 1/%h/%0d", pass_b, sig_b, k, REF_SIG, RUN_CYC);
      end
   endtask

   task automatic test_reset_midrun();
      int k;
      load_chain();
      pulse_start();
      repeat ((CL + 1) * 5 + 3) @(negedge clock);
      checks++;
      if (tc_a !== 1'b1 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre: got tc=%b busy=%b required 1/1", tc_a, busy_a);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (tc_a !== 1'b0 || busy_a !== 1'b0 || sig_a !== 16'h0000 || done_a !== 1'b0 || ci_a !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got tc=%b busy=%b done=%b ci=%b sig=%h required 0/0/0/0/0000",
                  tc_a, busy_a, done_a, ci_a, sig_a);
      end
      pulse_start();
      wait_done(k);
      checks++;
      if (sig_a !== REF_SIG || k != RUN_CYC) begin
         errors++;
         $display("FAIL after_reset_run: got sig=%h cycles=%0d required %h/%0d", sig_a, k, REF_SIG, RUN_CYC);
      end
   endtask

   task automatic test_start_while_busy();
      int k, poke;
      poke = $urandom_range(1, RUN_CYC - 1);
      pulse_start();
      k = 0;
      while (done_a !== 1'b1 && k < RUN_CYC + 40) begin
         start = (k == poke);
         @(negedge clock);
         k++;
      end
      start = 1'b0;
      checks++;
      if (k != RUN_CYC || sig_a !== REF_SIG) begin
         errors++;
         $display("FAIL start_ignored poke=%0d: got cycles=%0d sig=%h required %0d/%h", poke, k, sig_a, RUN_CYC, REF_SIG);
      end
   endtask

   initial begin
      logic [15:0] l;
      reset      = 1'b1;
      start      = 1'b0;
      chain_load = 1'b0;
      chain_seed = '0;
      stuck3     = 1'b0;
      tie_en     = 1'b0;
      tie_val    = 1'b0;
      l = SEED;
      for (int n = 0; n < NBITS; n++) begin
         stream[n] = l[0];
         l = (l >> 1) ^ (l[0] ? LTAPS : 16'h0000);
      end
      @(negedge clock);
      test_reset();
      test_shift_pattern();
      test_full_run();
      test_tied_signature();
      test_stuck_fault();
      test_reset_midrun();
      test_start_while_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
